// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and the arbiter that shares it:
// opcodes, legality check and the arbiter FSM state type.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_LAST = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    function automatic logic op_illegal(input logic [2:0] op);
        return (op > OP_LAST);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters, the response consumer
// and alu_arbiter. master = requesters and consumer, slave = arbiter.
interface alu_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_id;
    logic             rsp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_result, rsp_id, rsp_err
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_result, rsp_id, rsp_err
    );

endinterface

// File: rtl/alu.sv
// Fixed 8-bit combinational ALU. ADD/SUB wrap modulo 256; illegal opcodes
// produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] result
);

    // Opcode decode
    always_comb begin
        result = 8'h00;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one alu between two requesters. One operation in
// flight: IDLE accepts, EXEC registers the result, RESP holds it until taken.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    state_t           state_r;
    logic             prio_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic             id_r;

    logic             rsp_valid_r;
    logic [WIDTH-1:0] rsp_result_r;
    logic             rsp_id_r;
    logic             rsp_err_r;

    logic             grant0_s;
    logic             grant1_s;
    logic [7:0]       alu_result_s;

    // Grant selection: a lone requester always wins, contention goes to prio_r
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant0_s = ~prio_r;
            grant1_s = prio_r;
        end else begin
            grant0_s = bus.req0_valid;
            grant1_s = bus.req1_valid;
        end
    end

    // Ready is gated by rst so nothing can be accepted while reset is asserted
    assign bus.req0_ready = (state_r == IDLE) && !rst && grant0_s;
    assign bus.req1_ready = (state_r == IDLE) && !rst && grant1_s;

    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_err    = rsp_err_r;

    alu u_alu (
        .a      (a_r),
        .b      (b_r),
        .op     (op_r),
        .result (alu_result_s)
    );

    // Arbiter FSM with operand capture and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            prio_r       <= 1'b0;
            a_r          <= '0;
            b_r          <= '0;
            op_r         <= 3'b000;
            id_r         <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= '0;
            rsp_id_r     <= 1'b0;
            rsp_err_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req0_ready) begin
                        a_r     <= bus.req0_a;
                        b_r     <= bus.req0_b;
                        op_r    <= bus.req0_op;
                        id_r    <= 1'b0;
                        prio_r  <= 1'b1;
                        state_r <= EXEC;
                    end else if (bus.req1_ready) begin
                        a_r     <= bus.req1_a;
                        b_r     <= bus.req1_b;
                        op_r    <= bus.req1_op;
                        id_r    <= 1'b1;
                        prio_r  <= 1'b0;
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    rsp_result_r <= alu_result_s;
                    rsp_id_r     <= id_r;
                    rsp_err_r    <= op_illegal(op_r);
                    rsp_valid_r  <= 1'b1;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares one combinational 8-bit `alu` datapath between two requesters (e.g. a host port and a DMA/sequencer port).
- Round-robin arbitration; valid/ready handshake on the request side; operands and opcode captured into registers.
- Result registered and returned on a single response channel tagged with the requester ID.
- Sits between the requesters and `alu`; it is the only block that drives `alu` inputs.

## Interface
- `WIDTH`, 8: operand/result width; must be 8 (`alu` is fixed 8-bit).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 operation accepted this cycle.
- `req0_a`, `req0_b` in WIDTH: requester 0 operands.
- `req0_op` in 3: requester 0 opcode.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as above, for requester 1.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_result` out WIDTH: ALU result.
- `rsp_id` out 1: requester that issued the operation.
- `rsp_err` out 1: opcode was illegal (101–111).

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If no `reqN_valid`, stay in IDLE.
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester selected by priority pointer `prio`.
  - `reqN_ready` is combinational and high only in IDLE, only for the granted requester, and only while `rst` is low; at most one ready is high per cycle.
  - On handshake: capture a, b, op and the ID into operand registers; set `prio` to the non-granted requester; go to EXEC.
- **EXEC**
  - `alu` sees the captured operands.
  - Register the ALU output into `rsp_result`, the ID into `rsp_id`, and `rsp_err` = (op > 3'b100); go to RESP.
- **RESP**
  - `rsp_valid` high; `rsp_result`, `rsp_id` and `rsp_err` held stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`: deassert `rsp_valid`, go to IDLE.
  - No new request is accepted in EXEC or RESP.
- Arithmetic: ADD and SUB wrap modulo 2^8; no carry or borrow is output.
- Illegal opcode: result is 0 and `rsp_err` = 1.
- `prio` updates only on a grant; a lone requester does not lose its turn through a grant it never competed for.
- Request inputs are ignored except during the handshake cycle; they may change freely afterwards.

## Timing
- Reset values:
  - Outputs: `rsp_valid` = 0, `rsp_result` = 0, `rsp_id` = 0, `rsp_err` = 0, `req0_ready` = `req1_ready` = 0.
  - Internal: state = IDLE, `prio` = 0, operand registers = 0.
- Latency: handshake at edge T puts the state in EXEC during cycle T+1; `rsp_valid` is high from cycle T+2.
- With `rsp_ready` held high, `rsp_valid` is high for one cycle and the next accept can occur in cycle T+3. Peak throughput is one op per 3 cycles.
- Backpressure: `rsp_ready` low holds RESP indefinitely; both `reqN_ready` stay low meanwhile.
- Reset mid-operation (EXEC or RESP): the in-flight op is dropped and no response is produced; state returns to IDLE immediately (asynchronously).
- Release of reset: first grant possible in the first cycle after deassertion. With both requesters valid, requester 0 wins.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams: `OP_ADD`=000, `OP_SUB`=001, `OP_AND`=010, `OP_OR`=011, `OP_XOR`=100.
  - `OP_LAST`=100 for the legality check.
  - FSM state typedef (IDLE/EXEC/RESP).
- Sub-module: instantiate the existing `alu` unchanged, fed from the operand registers. No other sub-modules; the arbitration logic stays inline.

## Test plan
- **Single op:** req0 {a=8'h05, b=8'h03, op=000} -> `req0_ready` in the same cycle; `rsp_valid` 2 cycles later with `rsp_result`=8'h08, `rsp_id`=0, `rsp_err`=0.
- **Wrap and contention:**
  - Stimulus: both valid from reset; req0 {8'hFF, 8'h01, 000}; req1 {8'h00, 8'h01, 001}.
  - Required: req0 served first with result 8'h00; then req1 with result 8'hFF, `rsp_id`=1. Grants alternate 0, 1, 0, 1 while both stay valid.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles in RESP -> `rsp_valid` and `rsp_result` stable and no `reqN_ready` pulses; on release, the next grant follows per `prio`.
- **Illegal op:** req1 {8'hAA, 8'h55, 110} -> `rsp_result`=8'h00, `rsp_err`=1, `rsp_id`=1; the next legal op (XOR 8'hAA, 8'h55) returns 8'hFF with `rsp_err`=0.
- **Reset mid-op:** assert `rst` during EXEC, then during RESP -> all outputs 0 immediately, no response emitted; after release, a fresh ADD 8'h10 + 8'h20 returns 8'h30.
- **Logic ops:** AND/OR/XOR on 8'hF0 and 8'h3C -> 8'h30, 8'hFC, 8'hCC, each with correct `rsp_id`.
